// File: rtl/step_accumulator_5b.sv
// Prescaled step accumulator: adds or subtracts `step` once every PRESCALE_DIV enabled clocks.
// Optional build macro STEP_ACC_SAT_EN adds sat_i, which clamps instead of wrapping.
module step_accumulator_5b #(
  parameter int WIDTH        = 5,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] step,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef STEP_ACC_SAT_EN
  input  logic             sat_i,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tick_o,
  output logic             wrap_o,
  output logic             zero_o
);

  localparam int PS_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             sat_en;
  logic             tick_now;
  logic [WIDTH:0]   acc_res;

`ifdef STEP_ACC_SAT_EN
  assign sat_en = sat_i;
`else
  assign sat_en = 1'b0;
`endif

  // Result packs {wrap, value}; on overflow with saturation the value pins at all-ones.
  function automatic logic [WIDTH:0] acc_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sat);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (sat && s[WIDTH]) return {1'b1, {WIDTH{1'b1}}};
    return s;
  endfunction

  function automatic logic [WIDTH:0] acc_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sat);
    logic             borrow;
    logic [WIDTH-1:0] d;
    borrow = (b > a);
    d      = a - b;
    if (sat && borrow) return {1'b1, {WIDTH{1'b0}}};
    return {borrow, d};
  endfunction

  assign tick_now = en && (ps_q == PS_LAST);
  assign acc_res  = dir ? acc_sub(count_q, step, sat_en) : acc_add(count_q, step, sat_en);

  always_comb begin
    ps_d    = ps_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      // Load wins over a coincident tick and restarts the prescaler.
      count_d = load_val;
      ps_d    = '0;
    end else if (tick_now) begin
      ps_d    = '0;
      count_d = acc_res[WIDTH-1:0];
      tick_d  = 1'b1;
      wrap_d  = acc_res[WIDTH];
    end else if (en) begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q    <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count  = count_q;
  assign tick_o = tick_q;
  assign wrap_o = wrap_q;
  assign zero_o = (count_q == '0);

endmodule
